// File: rtl/prim_fifo_sync_buf.sv
// Synchronous single-clock FIFO with wrap-phase pointers, register-array storage,
// optional empty pass-through and a pointer integrity flag.
module prim_fifo_sync_buf #(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 4,
  parameter bit          Pass              = 1'b1,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned PtrW             = $clog2(Depth) + 1,
  localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              err_o
);

  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0]  wptr_r, rptr_r;
  logic [IdxW-1:0]  widx_s, ridx_s;
  logic             wphase_s, rphase_s;
  logic             empty_s, full_s, pass_s, wr_en_s, rd_en_s;
  logic [Width-1:0] mem_r [Depth];

  // Index wraps from Depth-1 to 0 and flips the phase bit, so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
      return {~p[PtrW-1], {IdxW{1'b0}}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign widx_s   = wptr_r[IdxW-1:0];
  assign ridx_s   = rptr_r[IdxW-1:0];
  assign wphase_s = wptr_r[PtrW-1];
  assign rphase_s = rptr_r[PtrW-1];

  // Status decode, handshakes and read-side output mux.
  always_comb begin
    empty_s  = (widx_s == ridx_s) && (wphase_s == rphase_s);
    full_s   = (widx_s == ridx_s) && (wphase_s != rphase_s);
    pass_s   = Pass && empty_s && wvalid_i && rready_i;
    wready_o = ~full_s;
    full_o   = full_s;
    wr_en_s  = wvalid_i && !full_s && !pass_s;
    rd_en_s  = !empty_s && rready_i;
    err_o    = (DepthW'(widx_s) >= DepthW'(Depth)) || (DepthW'(ridx_s) >= DepthW'(Depth));

    if (!empty_s) begin
      rvalid_o = 1'b1;
      rdata_o  = mem_r[ridx_s];
    end else if (Pass) begin
      rvalid_o = wvalid_i;
      rdata_o  = wdata_i;
    end else begin
      rvalid_o = 1'b0;
      rdata_o  = mem_r[ridx_s];
    end
    if (OutputZeroIfEmpty && !rvalid_o) begin
      rdata_o = {Width{1'b0}};
    end else begin
      rdata_o = rdata_o;
    end

    if (full_s) begin
      depth_o = DepthW'(Depth);
    end else if (widx_s >= ridx_s) begin
      depth_o = DepthW'(widx_s) - DepthW'(ridx_s);
    end else begin
      depth_o = DepthW'(Depth) - DepthW'(ridx_s) + DepthW'(widx_s);
    end
  end

  // Pointer registers; clear wins over any handshake in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
    end else if (clr_i) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
    end else begin
      if (wr_en_s) wptr_r <= ptr_inc(wptr_r);
      if (rd_en_s) rptr_r <= ptr_inc(rptr_r);
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !clr_i && (DepthW'(widx_s) < DepthW'(Depth))) begin
      mem_r[widx_s] <= wdata_i;
    end
  end

  prim_fifo_sync_buf_chk #(
    .Width  (Width),
    .Depth  (Depth),
    .DepthW (DepthW)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wvalid (wvalid_i),
    .wready (wready_o),
    .full   (full_o),
    .rvalid (rvalid_o),
    .rdata  (rdata_o),
    .depth  (depth_o)
  );

endmodule

// Protocol and integrity properties for prim_fifo_sync_buf.
module prim_fifo_sync_buf_chk #(
  parameter int unsigned Width  = 16,
  parameter int unsigned Depth  = 4,
  parameter int unsigned DepthW = 3
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              wvalid,
  input logic              wready,
  input logic              full,
  input logic              rvalid,
  input logic [Width-1:0]  rdata,
  input logic [DepthW-1:0] depth
);

  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wvalid && wready && full));

  a_depth_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    depth <= DepthW'(Depth));

  a_rdata_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid |-> !$isunknown(rdata));

endmodule

// File: tb/tb_prim_fifo_sync_buf.sv
// Scoreboard bench: a Depth=4 pass-through FIFO and a Depth=3 registered FIFO
// checked against small occupancy models and expected-data queues.
module tb_prim_fifo_sync_buf;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        clr4, wv4, rr4;
  logic [15:0] wd4;
  logic        wrdy4, rv4, full4, err4;
  logic [15:0] rd4;
  logic [2:0]  dep4;

  logic        clr3, wv3, rr3;
  logic [15:0] wd3;
  logic        wrdy3, rv3, full3, err3;
  logic [15:0] rd3;
  logic [1:0]  dep3;

  int checks = 0;
  int errors = 0;
  logic [15:0] q4[$];
  logic [15:0] q3[$];
  int cnt4 = 0;
  int cnt3 = 0;

  always #5 clk = ~clk;

  prim_fifo_sync_buf #(.Width(16), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr4), .wvalid_i(wv4), .wready_o(wrdy4),
    .wdata_i(wd4), .rvalid_o(rv4), .rready_i(rr4), .rdata_o(rd4), .full_o(full4),
    .depth_o(dep4), .err_o(err4));

  prim_fifo_sync_buf #(.Width(16), .Depth(3), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr3), .wvalid_i(wv3), .wready_o(wrdy3),
    .wdata_i(wd3), .rvalid_o(rv3), .rready_i(rr3), .rdata_o(rd3), .full_o(full3),
    .depth_o(dep3), .err_o(err3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle on the Depth=4 pass-through FIFO.
  task automatic cyc4(input logic wv, input logic [15:0] wd, input logic rr);
    logic m_empty, m_full;
    logic [15:0] exp_d;
    wv4 = wv; wd4 = wd; rr4 = rr; clr4 = 1'b0;
    @(negedge clk);
    m_empty = (cnt4 == 0);
    m_full  = (cnt4 == 4);
    check_val("d4_depth", 32'(dep4), 32'(cnt4));
    check_val("d4_full", 32'(full4), 32'(m_full));
    check_val("d4_wready", 32'(wrdy4), 32'(!m_full));
    check_val("d4_rvalid", 32'(rv4), m_empty ? 32'(wv) : 32'd1);
    check_val("d4_err", 32'(err4), 32'd0);
    if (m_empty) begin
      check_val("d4_rdata_empty", 32'(rd4), wv ? 32'(wd) : 32'd0);
    end else begin
      exp_d = q4[0];
      check_val("d4_rdata", 32'(rd4), 32'(exp_d));
      if (rr) begin
        void'(q4.pop_front());
        cnt4--;
      end
    end
    if (wv && !m_full && !(m_empty && rr)) begin
      q4.push_back(wd);
      cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle on the Depth=3 registered FIFO.
  task automatic cyc3(input logic wv, input logic [15:0] wd, input logic rr, input logic clr);
    logic m_full;
    logic [15:0] exp_d;
    wv3 = wv; wd3 = wd; rr3 = rr; clr3 = clr;
    @(negedge clk);
    m_full = (cnt3 == 3);
    check_val("d3_depth", 32'(dep3), 32'(cnt3));
    check_val("d3_full", 32'(full3), 32'(m_full));
    check_val("d3_wready", 32'(wrdy3), 32'(!m_full));
    check_val("d3_rvalid", 32'(rv3), 32'(cnt3 != 0));
    check_val("d3_err", 32'(err3), 32'd0);
    exp_d = (cnt3 != 0) ? q3[0] : 16'h0000;
    check_val("d3_rdata", 32'(rd3), 32'(exp_d));
    if (clr) begin
      q3.delete();
      cnt3 = 0;
    end else begin
      if (cnt3 != 0 && rr) begin
        void'(q3.pop_front());
        cnt3--;
      end
      if (wv && !m_full) begin
        q3.push_back(wd);
        cnt3++;
      end
    end
    @(posedge clk);
    #1;
    clr3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr4 = 1'b0; wv4 = 1'b0; rr4 = 1'b0; wd4 = 16'h0000;
    clr3 = 1'b0; wv3 = 1'b0; rr3 = 1'b0; wd3 = 16'h0000;
    #2;
    check_val("rst_depth", 32'(dep4), 32'd0);
    check_val("rst_full", 32'(full4), 32'd0);
    check_val("rst_wready", 32'(wrdy4), 32'd1);
    check_val("rst_rvalid3", 32'(rv3), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill to full, then a dropped fifth write, then drain in order.
    for (int i = 0; i < 4; i++) cyc4(1'b1, 16'hA000 + 16'(i), 1'b0);
    cyc4(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 4; i++) cyc4(1'b0, 16'h0000, 1'b1);
    cyc4(1'b0, 16'h0000, 1'b0);

    // Full with read and write in the same cycle: read taken, write dropped.
    for (int i = 0; i < 4; i++) cyc4(1'b1, 16'hC000 + 16'(i), 1'b0);
    cyc4(1'b1, 16'hDEAD, 1'b1);
    cyc4(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) cyc4(1'b0, 16'h0000, 1'b1);

    // Continuous streaming at occupancy 2 across several pointer wraps.
    cyc4(1'b1, 16'hD100, 1'b0);
    cyc4(1'b1, 16'hD101, 1'b0);
    for (int i = 0; i < 10; i++) cyc4(1'b1, 16'hD000 + 16'(i), 1'b1);
    cyc4(1'b0, 16'h0000, 1'b1);
    cyc4(1'b0, 16'h0000, 1'b1);

    // Empty pass-through leaves occupancy untouched.
    cyc4(1'b1, 16'h1234, 1'b1);
    cyc4(1'b0, 16'h0000, 1'b0);
    cyc4(1'b1, 16'h5678, 1'b0);
    cyc4(1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 40; i++)
      cyc4(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    wv4 = 1'b0; rr4 = 1'b0;

    // Depth=3: clear alongside a write, then non-power-of-2 wrapping.
    cyc3(1'b1, 16'hE000, 1'b0, 1'b0);
    cyc3(1'b1, 16'hE001, 1'b0, 1'b0);
    cyc3(1'b1, 16'hE002, 1'b0, 1'b1);
    cyc3(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc3(1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0);
    cyc3(1'b1, 16'hF0FF, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc3(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    cyc3(1'b1, 16'hE100, 1'b0, 1'b0);
    cyc3(1'b1, 16'hE101, 1'b0, 1'b0);
    wv3 = 1'b0; rr3 = 1'b0;

    // Asynchronous reset pulse between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_depth3", 32'(dep3), 32'd0);
    check_val("arst_rvalid3", 32'(rv3), 32'd0);
    check_val("arst_rdata3", 32'(rd3), 32'd0);
    check_val("arst_full3", 32'(full3), 32'd0);
    check_val("arst_wready3", 32'(wrdy3), 32'd1);
    check_val("arst_depth4", 32'(dep4), 32'd0);
    #2;
    rst_n = 1'b1;
    q3.delete(); cnt3 = 0;
    q4.delete(); cnt4 = 0;
    @(posedge clk);
    #1;
    cyc3(1'b1, 16'hE200, 1'b0, 1'b0);
    cyc3(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc3(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
